// File: rtl/mem_access_stage.sv
// MEM stage: captures one EX/MEM instruction, runs its data-memory access on a req/gnt/rvalid bus, presents it to MEM/WB.
// Optional alignment check enabled by defining MEM_STAGE_MISALIGN_CHECK_EN (adds misalign_o).
module mem_access_stage #(
  parameter int AddrWidth        = 64,
  parameter int DataWidth        = 32,
  parameter bit ClearDataOnReset = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [63:0]          result_i,
  input  logic [DataWidth-1:0] MuxRes_i,
  input  logic [3:0]           rd_i,
  input  logic                 RegWrite_i,
  input  logic                 MemWrite_i,
  input  logic                 MemRead_i,
  input  logic                 MemToReg_i,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [AddrWidth-1:0] dmem_addr_o,
  output logic [DataWidth-1:0] dmem_wdata_o,
  input  logic                 dmem_gnt_i,
  input  logic                 dmem_rvalid_i,
  input  logic [DataWidth-1:0] dmem_rdata_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [63:0]          result_o,
  output logic [DataWidth-1:0] mem_data_o,
  output logic [3:0]           rd_o,
  output logic                 RegWrite_o,
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  output logic                 misalign_o,
`endif
  output logic                 MemToReg_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, FULL} state_t;

  state_t                 state, state_nxt;
  logic                   accept;
  logic                   is_mem;
  logic                   mem_go;
  logic [63:0]            result_p1;
  logic [DataWidth-1:0]   wdata_p1;
  logic [DataWidth-1:0]   mem_data_p1;
  logic [3:0]             rd_p1;
  logic                   regwrite_p1;
  logic                   memtoreg_p1;
  logic                   we_p1;

  assign is_mem = MemRead_i | MemWrite_i;

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  logic misalign_in;
  logic misalign_p1;
  assign misalign_in = is_mem & (result_i[1:0] != 2'b00);
  assign mem_go      = is_mem & ~misalign_in;
  assign misalign_o  = misalign_p1;
`else
  assign mem_go      = is_mem;
`endif

  always_comb begin
    state_nxt = state;
    ready_o   = 1'b0;
    case (state)
      IDLE: ready_o = 1'b1;
      REQ:  if (dmem_gnt_i) state_nxt = we_p1 ? FULL : RESP;
      RESP: if (dmem_rvalid_i) state_nxt = FULL;
      FULL: begin
        if (ready_i) begin
          ready_o   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A capture overrides the drain-to-IDLE path so back-to-back issue costs no bubble.
    if (valid_i && ready_o) state_nxt = mem_go ? REQ : FULL;
  end

  assign accept = valid_i & ready_o & ~reset_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  always_ff @(posedge clk_i) begin
    if (reset_i)     misalign_p1 <= 1'b0;
    else if (accept) misalign_p1 <= misalign_in;
  end
`endif

  // Capture stage: EX/MEM inputs -> held registers; RESP fills mem_data.
  always_ff @(posedge clk_i) begin
    if (ClearDataOnReset && reset_i) begin
      result_p1   <= '0;
      wdata_p1    <= '0;
      mem_data_p1 <= '0;
      rd_p1       <= '0;
      regwrite_p1 <= 1'b0;
      memtoreg_p1 <= 1'b0;
      we_p1       <= 1'b0;
    end else if (!reset_i) begin
      if (accept) begin
        result_p1   <= result_i;
        wdata_p1    <= MuxRes_i;
        mem_data_p1 <= '0;
        rd_p1       <= rd_i;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
        regwrite_p1 <= RegWrite_i & ~misalign_in;
`else
        regwrite_p1 <= RegWrite_i;
`endif
        memtoreg_p1 <= MemToReg_i;
        we_p1       <= MemWrite_i;
      end else if (state == RESP && dmem_rvalid_i) begin
        mem_data_p1 <= dmem_rdata_i;
      end
    end
  end

  assign dmem_req_o   = (state == REQ);
  assign dmem_we_o    = we_p1;
  assign dmem_addr_o  = result_p1[AddrWidth-1:0];
  assign dmem_wdata_o = wdata_p1;

  assign valid_o    = (state == FULL);
  assign result_o   = result_p1;
  assign mem_data_o = mem_data_p1;
  assign rd_o       = rd_p1;
  assign RegWrite_o = regwrite_p1;
  assign MemToReg_o = memtoreg_p1;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU op, store with delayed grant, load, backpressure, reset mid-load.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [63:0] result_i = '0;
  logic [31:0] MuxRes_i = '0;
  logic [3:0]  rd_i = '0;
  logic        RegWrite_i = 1'b0, MemWrite_i = 1'b0, MemRead_i = 1'b0, MemToReg_i = 1'b0;
  logic        dmem_req_o, dmem_we_o;
  logic [63:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [63:0] result_o;
  logic [31:0] mem_data_o;
  logic [3:0]  rd_o;
  logic        RegWrite_o, MemToReg_o;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  logic        misalign_o;
`endif

  int errors = 0;
  int checks = 0;

  mem_access_stage dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .result_i(result_i), .MuxRes_i(MuxRes_i), .rd_i(rd_i),
    .RegWrite_i(RegWrite_i), .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i), .MemToReg_i(MemToReg_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .mem_data_o(mem_data_o),
    .rd_o(rd_o), .RegWrite_o(RegWrite_o),
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    .misalign_o(misalign_o),
`endif
    .MemToReg_o(MemToReg_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic v, input logic [63:0] res, input logic [31:0] wd, input logic [3:0] rd,
                        input logic rw, input logic mw, input logic mr, input logic m2r);
    valid_i = v; result_i = res; MuxRes_i = wd; rd_i = rd;
    RegWrite_i = rw; MemWrite_i = mw; MemRead_i = mr; MemToReg_i = m2r;
  endtask

  initial begin
    // reset
    step(); step();
    check("rst_valid", valid_o, 0);
    check("rst_req", dmem_req_o, 0);
    reset_i = 1'b0;
    #1;
    check("idle_ready", ready_o, 1);

    // ALU op; a stray grant in IDLE must be ignored
    dmem_gnt_i = 1'b1;
    ready_i = 1'b0;
    set_op(1, 64'h10, 32'h0, 4'd5, 1, 0, 0, 0);
    step();
    dmem_gnt_i = 1'b0;
    set_op(0, 64'h0, 32'h0, 4'd0, 0, 0, 0, 0);
    check("alu_valid", valid_o, 1);
    check("alu_result", result_o, 64'h10);
    check("alu_rd", rd_o, 5);
    check("alu_regwrite", RegWrite_o, 1);
    check("alu_req", dmem_req_o, 0);
    check("alu_memdata", mem_data_o, 0);
    ready_i = 1'b1;
    step();
    check("alu_drain", valid_o, 0);

    // store, grant in third REQ cycle; inputs scrambled to prove addr/wdata come from captured state
    set_op(1, 64'h100, 32'hDEADBEEF, 4'd0, 0, 1, 0, 0);
    step();
    set_op(0, 64'hFFFF, 32'h11111111, 4'd9, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      check("st_req", dmem_req_o, 1);
      check("st_we", dmem_we_o, 1);
      check("st_addr", dmem_addr_o, 64'h100);
      check("st_wdata", dmem_wdata_o, 32'hDEADBEEF);
      check("st_ready", ready_o, 0);
      check("st_valid_early", valid_o, 0);
      if (i == 2) dmem_gnt_i = 1'b1;
      step();
    end
    dmem_gnt_i = 1'b0;
    set_op(0, 64'h0, 32'h0, 4'd0, 0, 0, 0, 0);
    check("st_valid", valid_o, 1);
    check("st_req_drop", dmem_req_o, 0);
    check("st_memdata", mem_data_o, 0);
    step();
    check("st_drain", valid_o, 0);

    // load, immediate grant, rvalid two cycles later, then backpressure
    ready_i = 1'b0;
    set_op(1, 64'h40, 32'h0, 4'd7, 1, 0, 1, 1);
    dmem_gnt_i = 1'b1;
    step();
    set_op(0, 64'h0, 32'h0, 4'd0, 0, 0, 0, 0);
    check("ld_req", dmem_req_o, 1);
    check("ld_we", dmem_we_o, 0);
    check("ld_addr", dmem_addr_o, 64'h40);
    step();
    dmem_gnt_i = 1'b0;
    check("ld_resp_req", dmem_req_o, 0);
    check("ld_resp_valid", valid_o, 0);
    step();
    check("ld_wait_valid", valid_o, 0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'hCAFEF00D;
    step();
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i = 32'h0;
    check("ld_valid", valid_o, 1);
    check("ld_data", mem_data_o, 32'hCAFEF00D);
    check("ld_m2r", MemToReg_o, 1);
    check("ld_rd", rd_o, 7);
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_valid", valid_o, 1);
      check("bp_data", mem_data_o, 32'hCAFEF00D);
      check("bp_result", result_o, 64'h40);
      check("bp_ready", ready_o, 0);
    end
    ready_i = 1'b1;
    set_op(1, 64'h55, 32'h0, 4'd3, 1, 0, 0, 0);
    #1;
    check("b2b_ready", ready_o, 1);
    step();
    set_op(0, 64'h0, 32'h0, 4'd0, 0, 0, 0, 0);
    check("b2b_valid", valid_o, 1);
    check("b2b_result", result_o, 64'h55);
    check("b2b_rd", rd_o, 3);
    check("b2b_memdata", mem_data_o, 0);
    check("b2b_m2r", MemToReg_o, 0);
    step();
    check("b2b_drain", valid_o, 0);

    // MemRead and MemWrite both set: a store, load data stays zero
    set_op(1, 64'h200, 32'h12345678, 4'd2, 0, 1, 1, 0);
    dmem_gnt_i = 1'b1;
    step();
    set_op(0, 64'h0, 32'h0, 4'd0, 0, 0, 0, 0);
    check("rw_req", dmem_req_o, 1);
    check("rw_we", dmem_we_o, 1);
    step();
    dmem_gnt_i = 1'b0;
    check("rw_valid", valid_o, 1);
    check("rw_memdata", mem_data_o, 0);
    step();

    // reset while waiting for load data
    set_op(1, 64'h80, 32'h0, 4'd1, 1, 0, 1, 1);
    dmem_gnt_i = 1'b1;
    step();
    set_op(0, 64'h0, 32'h0, 4'd0, 0, 0, 0, 0);
    step();
    dmem_gnt_i = 1'b0;
    check("rr_in_resp", dmem_req_o, 0);
    reset_i = 1'b1;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'hBADBAD00;
    step();
    reset_i = 1'b0;
    check("rr_valid", valid_o, 0);
    check("rr_req", dmem_req_o, 0);
    step();
    dmem_rvalid_i = 1'b0;
    check("rr_valid_after", valid_o, 0);
    check("rr_idle", ready_o, 1);

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    set_op(1, 64'h102, 32'h0, 4'd4, 1, 0, 1, 1);
    step();
    set_op(0, 64'h0, 32'h0, 4'd0, 0, 0, 0, 0);
    check("mis_req", dmem_req_o, 0);
    check("mis_valid", valid_o, 1);
    check("mis_flag", misalign_o, 1);
    check("mis_regwrite", RegWrite_o, 0);
    step();
    set_op(1, 64'h104, 32'h0, 4'd4, 1, 0, 1, 1);
    step();
    set_op(0, 64'h0, 32'h0, 4'd0, 0, 0, 0, 0);
    check("al_req", dmem_req_o, 1);
    check("al_flag", misalign_o, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
